// File: rtl/uart_bus_bridge.sv
// UART-framed bus master: parses A5/CMD/ADDR[/DATA] frames, runs one mem_valid/mem_ready cycle, replies ACK(+rdata) or NAK.
// Last rx byte -> mem_valid 1 cycle; mem_ready -> ACK 1 cycle; tx bytes hold on tx_ready low, rx bytes dropped while busy.
module uart_bus_bridge #(
  parameter int BUS_TIMEOUT = 1024,
  parameter int FRAME_GAP   = 50000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        err_timeout
);

  localparam int TW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam int GW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

  localparam logic [7:0] SOF_BYTE = 8'hA5;
  localparam logic [7:0] CMD_WR   = 8'h01;
  localparam logic [7:0] CMD_RD   = 8'h02;
  localparam logic [7:0] ACK_BYTE = 8'h5A;
  localparam logic [7:0] NAK_BYTE = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_BUS, S_RESP
  } state_t;

  state_t      state, state_nxt;
  logic        cmd_wr;
  logic        nak;
  logic        data_phase;
  logic [1:0]  byte_cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] to_cnt;

  logic in_frame;
  logic gap_expired;
  logic bus_timeout;
  logic tx_hs;
  logic resp_last;

  assign in_frame    = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA);
  assign gap_expired = in_frame && !rx_valid && (gap_cnt == GW'(FRAME_GAP - 1));
  assign bus_timeout = (state == S_BUS) && !mem_ready && (to_cnt == TW'(BUS_TIMEOUT - 1));
  assign tx_hs       = tx_valid && tx_ready;
  // A write ends after the status byte; a read ends after the fourth data byte.
  assign resp_last   = tx_hs && (nak || (!data_phase && cmd_wr) || (data_phase && byte_cnt == 2'd3));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_valid = 1'b0;
    mem_wstrb = 4'b0000;
    tx_valid  = 1'b0;
    tx_byte   = 8'h00;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: if (rx_valid && rx_byte == SOF_BYTE) state_nxt = S_CMD;
      S_CMD: begin
        if (gap_expired) state_nxt = S_IDLE;
        else if (rx_valid) state_nxt = (rx_byte == CMD_WR || rx_byte == CMD_RD) ? S_ADDR : S_RESP;
      end
      S_ADDR: begin
        if (gap_expired) state_nxt = S_IDLE;
        else if (rx_valid && byte_cnt == 2'd3) state_nxt = cmd_wr ? S_DATA : S_BUS;
      end
      S_DATA: begin
        if (gap_expired) state_nxt = S_IDLE;
        else if (rx_valid && byte_cnt == 2'd3) state_nxt = S_BUS;
      end
      S_BUS: begin
        mem_valid = 1'b1;
        mem_wstrb = cmd_wr ? 4'b1111 : 4'b0000;
        if (mem_ready || bus_timeout) state_nxt = S_RESP;
      end
      S_RESP: begin
        tx_valid = 1'b1;
        if (nak)              tx_byte = NAK_BYTE;
        else if (!data_phase) tx_byte = ACK_BYTE;
        else                  tx_byte = rdata_q[{byte_cnt, 3'b000} +: 8];
        if (resp_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmd_wr      <= 1'b0;
      nak         <= 1'b0;
      data_phase  <= 1'b0;
      byte_cnt    <= 2'd0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      gap_cnt     <= '0;
      to_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= bus_timeout;
      gap_cnt     <= (rx_valid || !in_frame) ? '0 : gap_cnt + 1'b1;
      to_cnt      <= (state == S_BUS) ? to_cnt + 1'b1 : '0;
      case (state)
        S_CMD: if (rx_valid) begin
          cmd_wr     <= (rx_byte == CMD_WR);
          nak        <= !(rx_byte == CMD_WR || rx_byte == CMD_RD);
          byte_cnt   <= 2'd0;
          data_phase <= 1'b0;
        end
        S_ADDR: if (rx_valid) begin
          // Word address only: the low two bits of A0 never reach the bus.
          addr_q[{byte_cnt, 3'b000} +: 8] <= (byte_cnt == 2'd0) ? {rx_byte[7:2], 2'b00} : rx_byte;
          byte_cnt <= byte_cnt + 2'd1;
        end
        S_DATA: if (rx_valid) begin
          wdata_q[{byte_cnt, 3'b000} +: 8] <= rx_byte;
          byte_cnt <= byte_cnt + 2'd1;
        end
        S_BUS: begin
          byte_cnt   <= 2'd0;
          data_phase <= 1'b0;
          if (mem_ready) begin
            if (!cmd_wr) rdata_q <= mem_rdata;
          end else if (bus_timeout) begin
            nak <= 1'b1;
          end
        end
        S_RESP: if (tx_hs && !nak && !cmd_wr) begin
          if (!data_phase) data_phase <= 1'b1;
          else             byte_cnt   <= byte_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign mem_instr = 1'b0;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed + randomized frames against a frame-level reference model of the UART bus bridge.
module tb_uart_bus_bridge;

  localparam int BT = 64;
  localparam int FG = 300;
  localparam int IDLE_LIMIT = 3 * BT + 400;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        err_timeout;

  always #5 clk = ~clk;

  uart_bus_bridge #(.BUS_TIMEOUT(BT), .FRAME_GAP(FG)) dut (
    .clk(clk), .resetn(resetn),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .busy(busy), .err_timeout(err_timeout)
  );

  // Bus responder: ready after resp_delay cycles of mem_valid (0 = same cycle).
  int          bus_wait = 0;
  int          resp_delay = 0;
  bit          resp_en = 1'b1;
  logic [31:0] rd_word = 32'h0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) bus_wait <= 0;
    else         bus_wait <= (mem_valid && !mem_ready) ? bus_wait + 1 : 0;
  end
  assign mem_ready = mem_valid && resp_en && (bus_wait >= resp_delay);
  assign mem_rdata = rd_word;

  typedef struct {
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0]  s;
  } txn_t;

  txn_t       bus_q[$];
  logic [7:0] tx_q[$];
  int         valid_cycles = 0;
  int         to_pulses = 0;
  bit         tx_seen = 1'b0;
  bit         tx_rand = 1'b0;

  always @(negedge clk) begin
    if (mem_valid) valid_cycles++;
    if (mem_valid && mem_ready) bus_q.push_back('{mem_addr, mem_wdata, mem_wstrb});
    if (tx_valid) tx_seen = 1'b1;
    if (tx_valid && tx_ready) tx_q.push_back(tx_byte);
    if (err_timeout) to_pulses++;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (tx_rand) tx_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic clear_mon();
    bus_q.delete();
    tx_q.delete();
    valid_cycles = 0;
    to_pulses = 0;
    tx_seen = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                            input int gap);
    logic [7:0] b[$];
    b.push_back(8'hA5);
    b.push_back(cmd);
    if (cmd == 8'h01 || cmd == 8'h02) begin
      for (int i = 0; i < 4; i++) b.push_back(addr[8*i +: 8]);
      if (cmd == 8'h01) for (int i = 0; i < 4; i++) b.push_back(data[8*i +: 8]);
    end
    foreach (b[i]) begin
      if (i > 0) repeat (gap) tick();
      send_byte(b[i]);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < IDLE_LIMIT) begin
      tick();
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  // Reference model: one frame yields at most one bus transaction and a fixed reply.
  task automatic run_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] rdata, input int delay, input int gap, input bit chk_ack);
    logic [7:0] exp_tx[$];
    bit good;
    good = (cmd == 8'h01 || cmd == 8'h02);
    clear_mon();
    rd_word = rdata;
    resp_delay = delay;
    send_frame(cmd, addr, data, gap);
    if (good) check("mem_valid_latency", mem_valid, 1);
    if (chk_ack) begin
      tick();
      check("ack_latency_valid", tx_valid, 1);
      check("ack_latency_byte", tx_byte, 8'h5A);
    end
    wait_idle();
    if (!good) exp_tx.push_back(8'hEE);
    else begin
      exp_tx.push_back(8'h5A);
      if (cmd == 8'h02) for (int i = 0; i < 4; i++) exp_tx.push_back(rdata[8*i +: 8]);
    end
    check("bus_count", bus_q.size(), good ? 1 : 0);
    if (good && bus_q.size() == 1) begin
      check("bus_addr", bus_q[0].a, addr & 32'hFFFF_FFFC);
      check("bus_wstrb", bus_q[0].s, (cmd == 8'h01) ? 4'hF : 4'h0);
      if (cmd == 8'h01) check("bus_wdata", bus_q[0].w, data);
      check("bus_valid_cycles", valid_cycles, delay + 1);
    end
    check("tx_count", tx_q.size(), exp_tx.size());
    if (tx_q.size() == exp_tx.size())
      foreach (exp_tx[i]) check("tx_byte", tx_q[i], exp_tx[i]);
    check("no_timeout_pulse", to_pulses, 0);
  endtask

  initial begin
    logic [7:0] cmd;
    int r;

    // Reset state
    repeat (3) tick();
    check("rst_mem_valid", mem_valid, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("mem_instr", mem_instr, 0);
    resetn = 1'b1;
    repeat (2) tick();

    // Write with ready after 3 cycles, then read with same-cycle ready
    run_frame(8'h01, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 3, 0, 1'b0);
    run_frame(8'h02, 32'h0000_8030, 32'h0, 32'h1234_5678, 0, 0, 1'b1);

    // Bus timeout
    resp_en = 1'b0;
    clear_mon();
    send_frame(8'h02, 32'h0000_0044, 32'h0, 0);
    wait_idle();
    check("timeout_valid_cycles", valid_cycles, BT);
    check("timeout_pulses", to_pulses, 1);
    check("timeout_tx_count", tx_q.size(), 1);
    if (tx_q.size() == 1) check("timeout_nak", tx_q[0], 8'hEE);
    check("timeout_bus_count", bus_q.size(), 0);
    resp_en = 1'b1;

    // Noise byte and bad command, then a normal frame
    clear_mon();
    send_byte(8'h33);
    tick();
    check("noise_ignored_busy", busy, 0);
    send_byte(8'hA5);
    send_byte(8'h07);
    wait_idle();
    check("badcmd_tx_count", tx_q.size(), 1);
    if (tx_q.size() == 1) check("badcmd_nak", tx_q[0], 8'hEE);
    check("badcmd_bus_count", bus_q.size(), 0);
    run_frame(8'h01, 32'h0000_2007, 32'hCAFE_F00D, 32'h0, 1, 0, 1'b0);

    // Gap abort at exactly FG idle cycles, then a read is serviced
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    repeat (FG) tick();
    check("gap_abort_busy", busy, 0);
    check("gap_abort_tx", tx_q.size(), 0);
    run_frame(8'h02, 32'h0000_0100, 32'h0, 32'hA1B2_C3D4, 2, 0, 1'b0);
    check("gap_abort_no_bus_from_first", bus_q.size(), 1);
    // Byte arriving on the last permitted idle cycle keeps the frame alive
    run_frame(8'h01, 32'h0000_0200, 32'h0BAD_F00D, 32'h0, 0, FG - 1, 1'b0);

    // Transmit backpressure
    tx_ready = 1'b0;
    clear_mon();
    rd_word = 32'h8765_4321;
    resp_delay = 1;
    send_frame(8'h02, 32'h0000_0300, 32'h0, 0);
    r = 0;
    while (!tx_valid && r < IDLE_LIMIT) begin
      tick();
      r++;
    end
    check("bp_tx_valid", tx_valid, 1);
    for (int i = 0; i < 20; i++) begin
      check("bp_tx_hold", tx_byte, 8'h5A);
      tick();
    end
    tx_ready = 1'b1;
    wait_idle();
    check("bp_tx_count", tx_q.size(), 5);
    if (tx_q.size() == 5) begin
      check("bp_ack", tx_q[0], 8'h5A);
      check("bp_d0", tx_q[1], 8'h21);
      check("bp_d3", tx_q[4], 8'h87);
    end

    // Reset in the middle of a bus cycle
    clear_mon();
    resp_delay = 30;
    send_frame(8'h02, 32'h0000_0400, 32'h0, 0);
    repeat (3) tick();
    check("pre_reset_mem_valid", mem_valid, 1);
    #2 resetn = 1'b0;
    #1;
    check("reset_async_mem_valid", mem_valid, 0);
    check("reset_async_busy", busy, 0);
    tick();
    tick();
    resetn = 1'b1;
    tx_seen = 1'b0;
    repeat (20) tick();
    check("reset_no_response", tx_seen, 0);
    check("reset_no_bus", bus_q.size(), 0);
    run_frame(8'h02, 32'h0000_0500, 32'h0, 32'h5566_7788, 0, 0, 1'b0);

    // Randomized frames with random tx backpressure
    tx_rand = 1'b1;
    for (int k = 0; k < 24; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      cmd = 8'h01;
      else if (r < 8) cmd = 8'h02;
      else begin
        cmd = 8'($urandom_range(3, 255));
      end
      run_frame(cmd, $urandom, $urandom, $urandom, $urandom_range(0, 6), $urandom_range(0, 3), 1'b0);
    end
    tx_rand = 1'b0;
    tx_ready = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
